pipe_stage_skid: RTL and testbench

- Parametrised, elastic pipeline-stage register for the 5-stage BRISC-V core. It generalises the fixed execute→memory latch.
- Carries a generic payload: instruction, data bus and control vector. Uses a valid/ready handshake and a 2-entry skid buffer, so backpressure does not create a combinational ready path.
- Adds synchronous flush and NOP bubble insertion on empty/flush.
- Instantiated between any two pipe stages (decode→execute, execute→memory, memory→writeback).

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/pipe_payload_reg.sv | 40 ++++
 rtl/pipe_stage_skid.sv | 151 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and types for the elastic pipeline stage
// Purpose : NOP constant, occupancy encodings and the payload width helper
//           used by pipe_stage_skid and its payload registers.
// Ports   : none (package).
package pipe_pkg;

    // RISC-V canonical NOP: addi x0, x0, 0
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Payload = instruction + data lanes + control vector
    function automatic int payload_w(input int data_width, input int data_lanes,
                                     input int ctrl_width);
        return data_width * (1 + data_lanes) + ctrl_width;
    endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - W-bit payload register with load, load-bubble and hold
// Purpose : one storage slot of the skid stage. Reset and load_bubble both
//           force the bubble pattern; load captures d; otherwise holds.
// Ports   : clock, reset (sync, active-high), load, load_bubble, d[W], q[W].
module pipe_payload_reg #(
    parameter int           W      = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         load_bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // load_bubble wins over load so a flush always squashes the slot
    always_comb begin
        q_d = q_q;
        if (load_bubble) begin
            q_d = BUBBLE;
        end else if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= BUBBLE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline stage register with 2-entry skid buffer
// Purpose : valid/ready pipe latch between two core stages. The main slot
//           drives every output; the skid slot absorbs one payload when the
//           downstream stalls so ready_out comes only from registered state.
//           Supports synchronous flush and drives a NOP bubble when empty.
// Ports   : clock, reset (sync, active-high), flush
//           upstream   : valid_in, ready_out, instruction_in, data_in, ctrl_in
//           downstream : valid_out, ready_in, instruction_out, data_out, ctrl_out
//           occupancy  : entries held (0..2)
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DATA_LANES  = 2,
    parameter int                    CTRL_WIDTH  = 11,
    parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR   = DATA_WIDTH'(DEFAULT_NOP_INSTR)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             valid_in,
    output logic                             ready_out,
    input  logic [DATA_WIDTH-1:0]            instruction_in,
    input  logic [DATA_LANES*DATA_WIDTH-1:0] data_in,
    input  logic [CTRL_WIDTH-1:0]            ctrl_in,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic [DATA_WIDTH-1:0]            instruction_out,
    output logic [DATA_LANES*DATA_WIDTH-1:0] data_out,
    output logic [CTRL_WIDTH-1:0]            ctrl_out,
    output logic [1:0]                       occupancy
);

    localparam int PAYLOAD_W = payload_w(DATA_WIDTH, DATA_LANES, CTRL_WIDTH);
    localparam logic [PAYLOAD_W-1:0] BUBBLE_PAYLOAD =
        {NOP_INSTR, {(DATA_LANES*DATA_WIDTH){1'b0}}, CTRL_BUBBLE};

    occ_e state_q;
    occ_e state_d;

    logic                 accept;
    logic                 issue;
    logic                 main_load;
    logic                 main_bubble;
    logic                 main_from_skid;
    logic                 skid_load;
    logic                 skid_bubble;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] main_d;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;

    // Both handshake flags derive from state_q, so ready_out has no path from ready_in
    assign ready_out = (state_q != OCC_FULL);
    assign valid_out = (state_q != OCC_EMPTY);
    assign accept    = valid_in & ready_out;
    assign issue     = valid_out & ready_in;

    assign in_payload = {instruction_in, data_in, ctrl_in};
    assign main_d     = main_from_skid ? skid_q : in_payload;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_bubble    = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_bubble    = 1'b0;

        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    state_d   = OCC_ONE;
                    main_load = 1'b1;
                end
            end
            OCC_ONE: begin
                if (accept && issue) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    state_d   = OCC_FULL;
                    skid_load = 1'b1;
                end else if (issue) begin
                    state_d     = OCC_EMPTY;
                    main_bubble = 1'b1;
                end
            end
            OCC_FULL: begin
                // Older entry sits in main, so the skid entry moves up on issue
                if (issue) begin
                    state_d        = OCC_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d     = OCC_EMPTY;
                main_bubble = 1'b1;
                skid_bubble = 1'b1;
            end
        endcase

        // Flush squashes both slots and any coincident accept
        if (flush) begin
            state_d     = OCC_EMPTY;
            main_load   = 1'b0;
            skid_load   = 1'b0;
            main_bubble = 1'b1;
            skid_bubble = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_payload_reg #(
        .W      (PAYLOAD_W),
        .BUBBLE (BUBBLE_PAYLOAD)
    ) u_main (
        .clock       (clock),
        .reset       (reset),
        .load        (main_load),
        .load_bubble (main_bubble),
        .d           (main_d),
        .q           (main_q)
    );

    pipe_payload_reg #(
        .W      (PAYLOAD_W),
        .BUBBLE (BUBBLE_PAYLOAD)
    ) u_skid (
        .clock       (clock),
        .reset       (reset),
        .load        (skid_load),
        .load_bubble (skid_bubble),
        .d           (in_payload),
        .q           (skid_q)
    );

    assign instruction_out = main_q[PAYLOAD_W-1 -: DATA_WIDTH];
    assign data_out        = main_q[CTRL_WIDTH +: DATA_LANES*DATA_WIDTH];
    assign ctrl_out        = main_q[CTRL_WIDTH-1:0];
    assign occupancy       = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard testbench for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int            DW = 32;
    localparam int            NL = 3;
    localparam int            CW = 11;
    localparam int            PW = DW * (1 + NL) + CW;
    localparam logic [CW-1:0] CB  = 11'h2A5;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;
    localparam logic [PW-1:0] BUBBLE = {NOP, {(NL*DW){1'b0}}, CB};

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic             valid_in;
    logic             ready_out;
    logic [DW-1:0]    instruction_in;
    logic [NL*DW-1:0] data_in;
    logic [CW-1:0]    ctrl_in;
    logic             valid_out;
    logic             ready_in;
    logic [DW-1:0]    instruction_out;
    logic [NL*DW-1:0] data_out;
    logic [CW-1:0]    ctrl_out;
    logic [1:0]       occupancy;

    pipe_stage_skid #(
        .DATA_WIDTH  (DW),
        .DATA_LANES  (NL),
        .CTRL_WIDTH  (CW),
        .CTRL_BUBBLE (CB),
        .NOP_INSTR   (NOP)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .instruction_in  (instruction_in),
        .data_in         (data_in),
        .ctrl_in         (ctrl_in),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .instruction_out (instruction_out),
        .data_out        (data_out),
        .ctrl_out        (ctrl_out),
        .occupancy       (occupancy)
    );

    always #5 clock = ~clock;

    int            n_tests = 0;
    int            n_fail  = 0;
    bit            started = 0;
    logic [PW-1:0] model_q[$];

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs must always show the oldest held payload (or a bubble)
    always @(negedge clock) begin
        int sz;
        if (reset) begin
            model_q.delete();
            started = 1;
        end else if (started) begin
            sz = model_q.size();
            chk("occupancy", PW'(occupancy), PW'(sz));
            chk("ready_out", PW'(ready_out), PW'(sz != 2));
            chk("valid_out", PW'(valid_out), PW'(sz != 0));
            if (sz > 0) begin
                chk("payload", {instruction_out, data_out, ctrl_out}, model_q[0]);
            end else begin
                chk("bubble", {instruction_out, data_out, ctrl_out}, BUBBLE);
            end
            if (valid_out && ready_in && sz > 0) begin
                void'(model_q.pop_front());
            end
            if (flush) begin
                model_q.delete();
            end
        end
    end

    // Stimulus side of the scoreboard: record every accepted payload
    always @(negedge clock) begin
        #1;
        if (!reset && !flush && valid_in && ready_out) begin
            model_q.push_back({instruction_in, data_in, ctrl_in});
        end
    end

    task automatic step(input logic v, input logic [DW-1:0] ins, input logic r,
                        input logic f, input logic rst);
        logic r0;
        logic rin_prev;
        @(posedge clock);
        #1;
        r0       = ready_out;
        rin_prev = ready_in;
        valid_in       = v;
        instruction_in = ins;
        data_in        = {$urandom, $urandom, $urandom};
        ctrl_in        = CW'($urandom);
        ready_in       = r;
        flush          = f;
        reset          = rst;
        #1;
        if (rin_prev !== ready_in) begin
            chk("ready_out_vs_ready_in", PW'(ready_out), PW'(r0));
        end
    endtask

    initial begin
        reset          = 1'b1;
        flush          = 1'b0;
        valid_in       = 1'b0;
        ready_in       = 1'b0;
        instruction_in = '0;
        data_in        = '0;
        ctrl_in        = '0;

        // Reset, then idle
        step(0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 32'h0, 0, 0, 0);

        // Streaming with no backpressure
        step(1, 32'h100, 1, 0, 0);
        step(1, 32'h104, 1, 0, 0);
        step(1, 32'h108, 1, 0, 0);
        step(0, 32'h0,   1, 0, 0);
        step(0, 32'h0,   1, 0, 0);

        // Backpressure: fill, hold, drain
        step(1, 32'hA, 0, 0, 0);
        step(1, 32'hB, 0, 0, 0);
        step(1, 32'hF, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);

        // Flush while FULL with a payload on the input
        step(1, 32'hA1, 0, 0, 0);
        step(1, 32'hB1, 0, 0, 0);
        step(1, 32'hC,  0, 1, 0);
        step(0, 32'h0,  1, 0, 0);
        step(0, 32'h0,  1, 0, 0);

        // Reset while FULL with valid_in and ready_in high
        step(1, 32'hA2, 0, 0, 0);
        step(1, 32'hB2, 0, 0, 0);
        step(1, 32'hE,  1, 0, 1);
        step(1, 32'hD,  1, 0, 0);
        step(0, 32'h0,  1, 0, 0);
        step(0, 32'h0,  1, 0, 0);

        // Random traffic with varying densities
        for (int blk = 0; blk < 10; blk++) begin
            int pv;
            int pr;
            pv = $urandom_range(20, 95);
            pr = $urandom_range(20, 95);
            for (int i = 0; i < 1000; i++) begin
                step($urandom_range(0, 99) < pv, $urandom, $urandom_range(0, 99) < pr,
                     $urandom_range(0, 99) == 0, $urandom_range(0, 999) == 0);
            end
        end

        for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
